lcd_ctrl_param: RTL and testbench
=================================

Name: lcd_ctrl_param

Overview:
- Parametrised HD44780-compatible character-LCD write controller; the next generation of the fixed-function LCD driver in the safe (sejf) design.
- Performs the power-on init sequence autonomously, then accepts command/data bytes over a valid/ready handshake.
- Supports an 8-bit or 4-bit bus, configurable E-pulse and settle timings, 1- or 2-row panels, and automatic cursor line-wrap.
- Sits between the safe's UI/keypad logic and the LCD pins, clocked by the 1 ms system tick.

Parameters:
BUS_WIDTH, 8, LCD bus mode: 8 or 4 (4-bit mode uses DB[7:4])
COLS, 16, visible columns per row, 1..40
ROWS, 2, rows, 1 or 2
E_HIGH, 1, clk_1ms cycles E is held high per pulse, >=1
CMD_WAIT, 1, settle cycles after an ordinary command or data byte
CLR_WAIT, 2, settle cycles after clear (0x01) or home (0x02/0x03)
PWR_WAIT, 20, cycles after reset before the first init pulse
INIT_STEP_WAIT, 5, settle cycles after each 0x3 wake-up pulse

Ports:
clk_1ms  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_rs  in  1  0 = command, 1 = data (DDRAM character)
req_data  in  8  byte to write
req_ready  out  1  controller idle; accepts a request when high with req_valid
init_done  out  1  high once the init sequence completes; stays high until reset
E  out  1  LCD enable strobe
RW  out  1  LCD read/write; tied 0 (write-only)
RS  out  1  LCD register select
DB  out  8  LCD data bus; in 4-bit mode DB[3:0] = 0

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-pulse): E=0, RW=0, RS=0, DB=0, req_ready=0, init_done=0, col=0, row=0. On release, the FSM restarts from PWR_WAIT.
- FSM states: PWR_WAIT, INIT (sequenced ROM index), IDLE, SETUP, PULSE, HOLD, SETTLE, WRAP.
- Pulse timing for one transfer unit (a byte, or a nibble in 4-bit mode):
  - SETUP: 1 cycle; RS and DB driven, E=0.
  - PULSE: E_HIGH cycles, E=1.
  - HOLD: 1 cycle, E=0; DB and RS still held.
  - A full byte in 4-bit mode sends two units, high nibble first, with no gap between them.
- Settle: after the last unit of a byte, SETTLE lasts CMD_WAIT cycles, or CLR_WAIT cycles if RS=0 and the byte is 0x01, 0x02 or 0x03.
- Init sequence:
  - 8-bit mode: 0x30, 0x30, 0x30 (each followed by INIT_STEP_WAIT), then FS, 0x08, 0x01, 0x06, 0x0C.
  - FS = 0x38 if ROWS=2, else 0x30.
  - 4-bit mode: single nibbles 0x3, 0x3, 0x3 (each followed by INIT_STEP_WAIT), then single nibble 0x2 (CMD_WAIT), then full bytes FS4, 0x08, 0x01, 0x06, 0x0C.
  - FS4 = 0x28 if ROWS=2, else 0x20.
  - Pulse counts: 8 pulses in 8-bit mode, 14 in 4-bit mode.
  - init_done and req_ready rise together in the cycle after the final SETTLE.
- Handshake:
  - A request is accepted on the edge where req_valid && req_ready.
  - req_ready drops in the next cycle and stays low until the transfer completes (including any WRAP).
  - req_valid while req_ready=0 is ignored; requests are not queued.
- Latency: in 8-bit mode, req_ready is low for 2+E_HIGH+wait cycles; in 4-bit mode, 2*(2+E_HIGH)+wait cycles.
- Cursor tracking:
  - Data write: col increments. If the new col equals COLS, then col=0, row toggles (ROWS=2) or stays 0 (ROWS=1), and the FSM enters WRAP.
  - WRAP issues command 0x80 | (row ? 0x40 : 0x00) with full pulse timing and CMD_WAIT before req_ready returns.
  - Command 0x01, 0x02 or 0x03: col=0, row=0.
  - Command 0x80..0xFF: row = data[6] (forced to 0 when ROWS=1), col = data[5:0].
  - All other commands: tracking unchanged.
- Output stability: DB and RS change only in SETUP or IDLE, never while E=1.

Test Plan:
- Defaults (8-bit). Reset high for cycles 0..1, then release -> exactly 8 E pulses carrying DB values 30,30,30,38,08,01,06,0C. init_done=1 no earlier than 20 cycles after release. RW=0 throughout.
- Defaults, after init. Send data 0x41 -> RS=1, DB=0x41 during a 1-cycle E pulse; req_ready low for 4 cycles. Then send command 0x01 -> req_ready low for 5 cycles, and col and row return to 0.
- BUS_WIDTH=4. Init -> 14 pulses; the first four have DB[7:4] = 3,3,3,2. Then send data 0xA5 -> two pulses with DB=0xA0 then DB=0x50, DB[3:0]=0, RS=1.
- Defaults. Send 16 data bytes -> the 16th is followed by an automatic command 0xC0 pulse (RS=0). Send 16 more -> an automatic 0x80 pulse follows.
- ROWS=1, COLS=8. Send 8 data bytes -> an automatic 0x80 is issued. Then command 0xC5 -> col=5, row=0, and 3 more data bytes trigger the wrap.
- Mid-pulse reset: assert reset while E=1 during a data write -> E=0 and req_ready=0 immediately (asynchronous); after release, the full init sequence reruns.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// HD44780-style write controller: runs the power-on init, then sends command/data bytes from a valid/ready handshake.
// Cursor tracking inserts a set-DDRAM-address command whenever the column wraps past COLS.
module lcd_ctrl_param #(
    parameter int BUS_WIDTH      = 8,
    parameter int COLS           = 16,
    parameter int ROWS           = 2,
    parameter int E_HIGH         = 1,
    parameter int CMD_WAIT       = 1,
    parameter int CLR_WAIT       = 2,
    parameter int PWR_WAIT       = 20,
    parameter int INIT_STEP_WAIT = 5
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       E,
    output logic       RW,
    output logic       RS,
    output logic [7:0] DB
);

    localparam bit NIB = (BUS_WIDTH == 4);
    localparam int INIT_LEN = NIB ? 9 : 8;
    localparam logic [7:0] FS = NIB ? ((ROWS == 2) ? 8'h28 : 8'h20)
                                    : ((ROWS == 2) ? 8'h38 : 8'h30);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_SETTLE, S_WRAP
    } state_t;

    // ROM entry: {byte, single_nibble, wake_up_step}
    function automatic logic [9:0] init_rom(input logic [3:0] idx);
        logic [9:0] r;
        if (NIB) begin
            case (idx)
                4'd0, 4'd1, 4'd2: r = {8'h30, 1'b1, 1'b1};
                4'd3:             r = {8'h20, 1'b1, 1'b0};
                4'd4:             r = {FS,    1'b0, 1'b0};
                4'd5:             r = {8'h08, 1'b0, 1'b0};
                4'd6:             r = {8'h01, 1'b0, 1'b0};
                4'd7:             r = {8'h06, 1'b0, 1'b0};
                default:          r = {8'h0C, 1'b0, 1'b0};
            endcase
        end else begin
            case (idx)
                4'd0, 4'd1, 4'd2: r = {8'h30, 1'b0, 1'b1};
                4'd3:             r = {FS,    1'b0, 1'b0};
                4'd4:             r = {8'h08, 1'b0, 1'b0};
                4'd5:             r = {8'h01, 1'b0, 1'b0};
                4'd6:             r = {8'h06, 1'b0, 1'b0};
                default:          r = {8'h0C, 1'b0, 1'b0};
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] db_unit(input logic [7:0] b, input logic lo);
        if (!NIB)
            return b;
        return lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
    endfunction

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  idx_q;
    logic [7:0]  byte_q;
    logic        single_q, step_q, nib_q, wrap_q;
    logic [5:0]  col_q;
    logic        row_q;
    logic        e_q, rs_q, ready_q, done_q;
    logic [7:0]  db_q;

    logic [9:0]  rom_d;
    logic        is_clr_d, last_unit_d;
    logic [15:0] settle_d;
    logic [5:0]  col_inc_d;
    logic [7:0]  wrap_cmd_d;

    always_comb begin
        rom_d       = init_rom(idx_q);
        is_clr_d    = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
        settle_d    = step_q   ? 16'(INIT_STEP_WAIT - 1) :
                      is_clr_d ? 16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);
        last_unit_d = !NIB || single_q || nib_q;
        col_inc_d   = col_q + 6'd1;
        wrap_cmd_d  = {1'b1, row_q, 6'd0};
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_q  <= S_PWR;
            cnt_q    <= 16'(PWR_WAIT - 1);
            idx_q    <= 4'd0;
            byte_q   <= 8'h00;
            single_q <= 1'b0;
            step_q   <= 1'b0;
            nib_q    <= 1'b0;
            wrap_q   <= 1'b0;
            col_q    <= 6'd0;
            row_q    <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            db_q     <= 8'h00;
        end else begin
            case (state_q)
                S_PWR: begin
                    if (cnt_q == 16'd0) state_q <= S_INIT;
                    else                cnt_q   <= cnt_q - 16'd1;
                end
                S_INIT: begin
                    byte_q   <= rom_d[9:2];
                    single_q <= rom_d[1];
                    step_q   <= rom_d[0];
                    rs_q     <= 1'b0;
                    nib_q    <= 1'b0;
                    db_q     <= db_unit(rom_d[9:2], 1'b0);
                    state_q  <= S_SETUP;
                end
                S_IDLE: begin
                    if (req_valid) begin
                        ready_q  <= 1'b0;
                        byte_q   <= req_data;
                        rs_q     <= req_rs;
                        single_q <= 1'b0;
                        step_q   <= 1'b0;
                        nib_q    <= 1'b0;
                        db_q     <= db_unit(req_data, 1'b0);
                        state_q  <= S_SETUP;
                        if (req_rs) begin
                            if (col_inc_d == 6'(COLS)) begin
                                col_q  <= 6'd0;
                                row_q  <= (ROWS == 2) ? ~row_q : 1'b0;
                                wrap_q <= 1'b1;
                            end else begin
                                col_q <= col_inc_d;
                            end
                        end else if (req_data == 8'h01 || req_data == 8'h02 || req_data == 8'h03) begin
                            col_q <= 6'd0;
                            row_q <= 1'b0;
                        end else if (req_data[7]) begin
                            col_q <= req_data[5:0];
                            row_q <= (ROWS == 2) ? req_data[6] : 1'b0;
                        end
                    end
                end
                S_SETUP, S_WRAP: begin
                    e_q     <= 1'b1;
                    cnt_q   <= 16'(E_HIGH - 1);
                    state_q <= S_PULSE;
                end
                S_PULSE: begin
                    if (cnt_q == 16'd0) begin
                        e_q     <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_HOLD: begin
                    // Low nibble follows the high nibble with no settle gap.
                    if (!last_unit_d) begin
                        nib_q   <= 1'b1;
                        db_q    <= db_unit(byte_q, 1'b1);
                        state_q <= S_SETUP;
                    end else begin
                        cnt_q   <= settle_d;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (!done_q) begin
                        if (idx_q == 4'(INIT_LEN - 1)) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= S_INIT;
                        end
                    end else if (wrap_q) begin
                        // WRAP doubles as the SETUP cycle of the address command.
                        wrap_q   <= 1'b0;
                        byte_q   <= wrap_cmd_d;
                        rs_q     <= 1'b0;
                        single_q <= 1'b0;
                        step_q   <= 1'b0;
                        nib_q    <= 1'b0;
                        db_q     <= db_unit(wrap_cmd_d, 1'b0);
                        state_q  <= S_WRAP;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_PWR;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign E         = e_q;
    assign RW        = 1'b0;
    assign RS        = rs_q;
    assign DB        = db_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: default 8-bit panel, 4-bit bus, and a 1x8 panel.
// Each LCD enable pulse is logged as {dut, RS, DB, width} and checked against hand-computed sequences.
module tb_lcd_ctrl_param;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] vld = 3'b000;
    logic [2:0] rsin = 3'b000;
    logic [7:0] dat [3];
    logic [2:0] rdy, done, e, rw, rso;
    logic [7:0] db [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lcd_ctrl_param u0 (
        .clk_1ms(clk), .reset(rst[0]), .req_valid(vld[0]), .req_rs(rsin[0]), .req_data(dat[0]),
        .req_ready(rdy[0]), .init_done(done[0]), .E(e[0]), .RW(rw[0]), .RS(rso[0]), .DB(db[0]));

    lcd_ctrl_param #(.BUS_WIDTH(4)) u4 (
        .clk_1ms(clk), .reset(rst[1]), .req_valid(vld[1]), .req_rs(rsin[1]), .req_data(dat[1]),
        .req_ready(rdy[1]), .init_done(done[1]), .E(e[1]), .RW(rw[1]), .RS(rso[1]), .DB(db[1]));

    lcd_ctrl_param #(.ROWS(1), .COLS(8)) u1 (
        .clk_1ms(clk), .reset(rst[2]), .req_valid(vld[2]), .req_rs(rsin[2]), .req_data(dat[2]),
        .req_ready(rdy[2]), .init_done(done[2]), .E(e[2]), .RW(rw[2]), .RS(rso[2]), .DB(db[2]));

    // Pulse monitor: log each E pulse when it falls; flag DB/RS movement while E is high.
    logic [18:0] pq[$];
    logic [2:0]  e_prev = 3'b000;
    logic [7:0]  cap_db [3];
    logic        cap_rs [3];
    int          wid [3];
    int          unstable = 0;
    int          rw_bad = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rw[k] !== 1'b0) rw_bad <= rw_bad + 1;
            if (e[k] && !e_prev[k]) begin
                cap_db[k] <= db[k];
                cap_rs[k] <= rso[k];
                wid[k]    <= 1;
            end else if (e[k]) begin
                wid[k] <= wid[k] + 1;
                if (db[k] !== cap_db[k] || rso[k] !== cap_rs[k]) unstable <= unstable + 1;
            end else if (e_prev[k]) begin
                pq.push_back({2'(k), cap_rs[k], cap_db[k], 8'(wid[k])});
            end
            e_prev[k] <= e[k];
        end
    end

    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (done[k] !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic send(input int k, input logic rs, input logic [7:0] d, output int low);
        int t = 0;
        low = 0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        vld[k] = 1'b1; rsin[k] = rs; dat[k] = d;
        @(posedge clk);
        #1 vld[k] = 1'b0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && low < 500) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({e[k], rdy[k], done[k], rso[k], rw[k], db[k]} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got E=%b rdy=%b done=%b RS=%b RW=%b DB=%h, want all 0",
                         k, e[k], rdy[k], done[k], rso[k], rw[k], db[k]);
            end
        end
    endtask

    task automatic test_init_8();
        int cyc;
        logic [7:0] exp8 [8];
        exp8 = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        pq.delete();
        rst[0] = 1'b0;
        wait_done(0, cyc);
        n_cmp++;
        if (cyc < 20 || cyc >= 2000) begin
            n_bad++; $display("FAIL init8_time: got %0d cycles, want >=20 and bounded", cyc);
        end
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_bad++; $display("FAIL init8_ready_with_done: got rdy=%b, want 1", rdy[0]);
        end
        n_cmp++;
        if (pq.size() != 8) begin
            n_bad++; $display("FAIL init8_count: got %0d pulses, want 8", pq.size());
        end
        for (int i = 0; i < 8 && i < pq.size(); i++) begin
            n_cmp++;
            if (pq[i] !== {2'd0, 1'b0, exp8[i], 8'd1}) begin
                n_bad++; $display("FAIL init8_pulse%0d: got %h, want %h", i, pq[i], {2'd0, 1'b0, exp8[i], 8'd1});
            end
        end
    endtask

    task automatic test_data_cmd();
        int low;
        pq.delete();
        send(0, 1'b1, 8'h41, low);
        n_cmp++;
        if (low != 4) begin n_bad++; $display("FAIL data_latency: got %0d, want 4", low); end
        n_cmp++;
        if (pq.size() != 1 || pq[0] !== {2'd0, 1'b1, 8'h41, 8'd1}) begin
            n_bad++; $display("FAIL data_pulse: got n=%0d p=%h, want 1 pulse %h", pq.size(), pq[0], {2'd0, 1'b1, 8'h41, 8'd1});
        end
        pq.delete();
        send(0, 1'b0, 8'h01, low);
        n_cmp++;
        if (low != 5) begin n_bad++; $display("FAIL clear_latency: got %0d, want 5", low); end
        n_cmp++;
        if (pq.size() != 1 || pq[0] !== {2'd0, 1'b0, 8'h01, 8'd1}) begin
            n_bad++; $display("FAIL clear_pulse: got n=%0d p=%h, want 1 pulse %h", pq.size(), pq[0], {2'd0, 1'b0, 8'h01, 8'd1});
        end
    endtask

    // Clear left col=0,row=0: the 16th byte wraps to row 1, the 32nd back to row 0.
    task automatic test_wrap();
        int low;
        for (int pass = 0; pass < 2; pass++) begin
            pq.delete();
            for (int i = 0; i < 16; i++) begin
                send(0, 1'b1, 8'(8'h61 + i), low);
                n_cmp++;
                if (low != ((i == 15) ? 8 : 4)) begin
                    n_bad++; $display("FAIL wrap_latency pass%0d byte%0d: got %0d, want %0d", pass, i, low, (i == 15) ? 8 : 4);
                end
            end
            n_cmp++;
            if (pq.size() != 17 || pq[16] !== {2'd0, 1'b0, (pass == 0) ? 8'hC0 : 8'h80, 8'd1}) begin
                n_bad++; $display("FAIL wrap_cmd pass%0d: got n=%0d last=%h, want 17 pulses ending %h",
                                  pass, pq.size(), pq[pq.size() - 1], {2'd0, 1'b0, (pass == 0) ? 8'hC0 : 8'h80, 8'd1});
            end
        end
    endtask

    task automatic test_4bit();
        int cyc, low;
        logic [7:0] exp14 [14];
        exp14 = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80, 8'h00, 8'h80,
                  8'h00, 8'h10, 8'h00, 8'h60, 8'h00, 8'hC0};
        pq.delete();
        rst[1] = 1'b0;
        wait_done(1, cyc);
        n_cmp++;
        if (pq.size() != 14) begin n_bad++; $display("FAIL init4_count: got %0d, want 14", pq.size()); end
        for (int i = 0; i < 14 && i < pq.size(); i++) begin
            n_cmp++;
            if (pq[i] !== {2'd1, 1'b0, exp14[i], 8'd1}) begin
                n_bad++; $display("FAIL init4_pulse%0d: got %h, want %h", i, pq[i], {2'd1, 1'b0, exp14[i], 8'd1});
            end
        end
        pq.delete();
        send(1, 1'b1, 8'hA5, low);
        n_cmp++;
        if (low != 7) begin n_bad++; $display("FAIL data4_latency: got %0d, want 7", low); end
        n_cmp++;
        if (pq.size() != 2 || pq[0] !== {2'd1, 1'b1, 8'hA0, 8'd1} || pq[1] !== {2'd1, 1'b1, 8'h50, 8'd1}) begin
            n_bad++; $display("FAIL data4_nibbles: got n=%0d %h %h, want A0 then 50 with RS=1", pq.size(), pq[0], pq[1]);
        end
    endtask

    task automatic test_rows1();
        int cyc, low;
        pq.delete();
        rst[2] = 1'b0;
        wait_done(2, cyc);
        n_cmp++;
        if (pq.size() != 8 || pq[3] !== {2'd2, 1'b0, 8'h30, 8'd1}) begin
            n_bad++; $display("FAIL rows1_fs: got n=%0d fs=%h, want 8 pulses with FS 30", pq.size(), pq[3]);
        end
        pq.delete();
        for (int i = 0; i < 8; i++) begin
            send(2, 1'b1, 8'(8'h30 + i), low);
            if (i == 7) begin
                n_cmp++;
                if (low != 8) begin n_bad++; $display("FAIL rows1_wrap_latency: got %0d, want 8", low); end
            end
        end
        n_cmp++;
        if (pq.size() != 9 || pq[8] !== {2'd2, 1'b0, 8'h80, 8'd1}) begin
            n_bad++; $display("FAIL rows1_wrap: got n=%0d last=%h, want 9 pulses ending 80", pq.size(), pq[pq.size() - 1]);
        end
        pq.delete();
        send(2, 1'b0, 8'hC5, low);
        for (int i = 0; i < 3; i++) begin
            send(2, 1'b1, 8'h58, low);
            n_cmp++;
            if (low != ((i == 2) ? 8 : 4)) begin
                n_bad++; $display("FAIL rows1_setaddr byte%0d: got %0d, want %0d", i, low, (i == 2) ? 8 : 4);
            end
        end
        n_cmp++;
        if (pq.size() != 5 || pq[4] !== {2'd2, 1'b0, 8'h80, 8'd1}) begin
            n_bad++; $display("FAIL rows1_row_forced: got n=%0d last=%h, want 5 pulses ending 80", pq.size(), pq[pq.size() - 1]);
        end
    endtask

    task automatic test_mid_reset();
        int cyc, t;
        logic [7:0] exp8 [8];
        exp8 = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        t = 0;
        @(negedge clk);
        while (rdy[0] !== 1'b1 && t < 500) begin @(negedge clk); t++; end
        vld[0] = 1'b1; rsin[0] = 1'b1; dat[0] = 8'h55;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (e[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_e_high: got E=%b, want 1", e[0]); end
        rst[0] = 1'b1;
        #1;
        n_cmp++;
        if ({e[0], rdy[0], done[0], db[0]} !== 11'h0) begin
            n_bad++; $display("FAIL midrst_async: got E=%b rdy=%b done=%b DB=%h, want all 0", e[0], rdy[0], done[0], db[0]);
        end
        repeat (2) @(negedge clk);
        pq.delete();
        rst[0] = 1'b0;
        wait_done(0, cyc);
        n_cmp++;
        if (cyc < 20 || cyc >= 2000 || pq.size() != 8) begin
            n_bad++; $display("FAIL midrst_reinit: got %0d cycles %0d pulses, want >=20 and 8", cyc, pq.size());
        end
        for (int i = 0; i < 8 && i < pq.size(); i++) begin
            n_cmp++;
            if (pq[i] !== {2'd0, 1'b0, exp8[i], 8'd1}) begin
                n_bad++; $display("FAIL midrst_pulse%0d: got %h, want %h", i, pq[i], {2'd0, 1'b0, exp8[i], 8'd1});
            end
        end
    endtask

    task automatic test_bus_rules();
        n_cmp++;
        if (unstable != 0) begin n_bad++; $display("FAIL db_stable_while_e: got %0d violations, want 0", unstable); end
        n_cmp++;
        if (rw_bad != 0) begin n_bad++; $display("FAIL rw_low: got %0d samples with RW!=0, want 0", rw_bad); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) dat[k] = 8'h00;
        test_reset();
        test_init_8();
        test_data_cmd();
        test_wrap();
        test_4bit();
        test_rows1();
        test_mid_reset();
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
